// File: rtl/tetris_pkg.sv
// tetris_pkg: state/move encodings, generator taps and 2x2 piece masks for tetris_board_engine
package tetris_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_MOVE  = 3'd2,
    S_LAND  = 3'd3,
    S_CLEAR = 3'd4,
    S_OVER  = 3'd5
  } state_t;
  localparam logic [1:0] MV_NOP   = 2'd0;
  localparam logic [1:0] MV_LEFT  = 2'd1;
  localparam logic [1:0] MV_RIGHT = 2'd2;
  localparam logic [1:0] MV_ROT   = 2'd3;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  // mask bit r*2+c inside the box; a clockwise turn sends (r,c) to (c,1-r)
  function automatic logic [3:0] rot_cw(input logic [3:0] m);
    return {m[1], m[3], m[0], m[2]};
  endfunction
  function automatic logic [3:0] piece_mask(input logic [1:0] t, input logic [1:0] r);
    logic [3:0] m;
    m = t == 2'd0 ? 4'b0011 : t == 2'd1 ? 4'b1101 : t == 2'd2 ? 4'b1111 : 4'b0001;
    for (int i = 0; i < 3; i++) if (i < int'(r)) m = rot_cw(m);
    return m;
  endfunction
endpackage

// File: rtl/tetris_lfsr.sv
// tetris_lfsr: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) stepping every cycle, low bits pick the next piece
module tetris_lfsr
  import tetris_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clka,
  input  logic       restart_n,
  output logic [1:0] spawn_type
);
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign spawn_type = lfsr_q[1:0];
endmodule

// File: rtl/tetris_board_engine.sv
// tetris_board_engine: falling 2x2-piece board with row clearing; TETRIS_SCORE_EN adds the cleared-row counter
module tetris_board_engine
  import tetris_pkg::*;
#(
  parameter int         BOARD_W   = 4,
  parameter int         BOARD_H   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                         clka,
  input  logic                         restart_n,
  input  logic                         start,
  input  logic                         move_valid,
  input  logic [1:0]                   move,
  output logic                         move_ready,
  input  logic                         drop_tick,
  output logic [BOARD_W*BOARD_H-1:0]   board_out,
  output logic [2:0]                   state_out,
  output logic [1:0]                   piece_out,
  output logic [1:0]                   rot_out,
  output logic [$clog2(BOARD_H)-1:0]   row_out,
  output logic [$clog2(BOARD_W)-1:0]   col_out,
  output logic                         rejected,
  output logic [15:0]                  lines_cleared
);
  localparam int N  = BOARD_W * BOARD_H;
  localparam int RW = $clog2(BOARD_H);
  localparam int CW = $clog2(BOARD_W);
  typedef logic [N-1:0] board_t;
  localparam board_t ONES     = '1;
  localparam board_t ROW_ONES = ONES >> (N - BOARD_W);
  state_t          state_q, state_d;
  board_t          board_q, board_d;
  logic [1:0]      piece_q, piece_d, rot_q, rot_d;
  logic [RW-1:0]   row_q, row_d, scan_q, scan_d;
  logic [CW-1:0]   col_q, col_d;
  logic            rej_q, rej_d;
  logic [1:0]      spawn_type;
  logic [3:0]      cur_mask, spawn_mask, try_mask;
  int              try_c;
  logic            accept, row_full;
  board_t          active, collapsed;
  function automatic board_t place(input logic [3:0] m, input int r, input int c);
    board_t p;
    p = '0;
    for (int i = 0; i < 4; i++) if (m[i]) p |= board_t'(1) << ((r + i / 2) * BOARD_W + c + i % 2);
    return p;
  endfunction
  // single legality test shared by spawn, drop, shift and rotate
  function automatic logic fits(input board_t b, input logic [3:0] m, input int r, input int c);
    return r >= 0 && r <= BOARD_H - 2 && c >= 0 && c <= BOARD_W - 2 && (place(m, r, c) & b) == '0;
  endfunction
  tetris_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clka       (clka),
    .restart_n  (restart_n),
    .spawn_type (spawn_type)
  );
  assign cur_mask   = piece_mask(piece_q, rot_q);
  assign spawn_mask = piece_mask(spawn_type, 2'd0);
  assign try_mask   = move == MV_ROT ? rot_cw(cur_mask) : cur_mask;
  assign try_c      = int'(col_q) + (move == MV_LEFT ? -1 : move == MV_RIGHT ? 1 : 0);
  assign active     = place(cur_mask, int'(row_q), int'(col_q));
  assign accept     = move_valid && move_ready;
  assign row_full   = ((board_q >> (int'(scan_q) * BOARD_W)) & ROW_ONES) == ROW_ONES;
  // rows above the scanned one slide down a row; the scanned row falls out
  assign collapsed  = (board_q & (ONES << ((int'(scan_q) + 1) * BOARD_W)))
                    | ((board_q & ~(ONES << (int'(scan_q) * BOARD_W))) << BOARD_W);
  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) begin
      state_q <= S_IDLE;
      board_q <= '0;
      piece_q <= '0;
      rot_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      scan_q  <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      piece_q <= piece_d;
      rot_q   <= rot_d;
      row_q   <= row_d;
      col_q   <= col_d;
      scan_q  <= scan_d;
      rej_q   <= rej_d;
    end
  always_comb begin
    state_d = state_q;
    board_d = board_q;
    piece_d = piece_q;
    rot_d   = rot_q;
    row_d   = row_q;
    col_d   = col_q;
    scan_d  = scan_q;
    rej_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = start ? S_GEN : S_IDLE;
      S_GEN: begin
        piece_d = spawn_type;
        rot_d   = '0;
        row_d   = '0;
        col_d   = CW'(BOARD_W / 2 - 1);
        state_d = fits(board_q, spawn_mask, 0, BOARD_W / 2 - 1) ? S_MOVE : S_OVER;
      end
      S_MOVE:
        if (drop_tick) begin
          if (fits(board_q, cur_mask, int'(row_q) + 1, int'(col_q))) row_d = row_q + 1'b1;
          else state_d = S_LAND;
        end else if (accept) begin
          if (fits(board_q, try_mask, int'(row_q), try_c)) begin
            col_d = CW'(try_c);
            rot_d = move == MV_ROT ? rot_q + 1'b1 : rot_q;
          end else rej_d = 1'b1;
        end
      S_LAND: begin
        board_d = board_q | active;
        scan_d  = RW'(BOARD_H - 1);
        state_d = S_CLEAR;
      end
      S_CLEAR:
        if (row_full) board_d = collapsed;
        else if (scan_q == '0) state_d = S_GEN;
        else scan_d = scan_q - 1'b1;
      S_OVER:
        if (start) begin
          board_d = '0;
          state_d = S_GEN;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    move_ready = state_q == S_MOVE && !drop_tick;
    board_out  = state_q == S_OVER ? ONES : (state_q == S_MOVE || state_q == S_LAND) ? board_q | active : board_q;
  end
  assign state_out = state_q;
  assign piece_out = piece_q;
  assign rot_out   = rot_q;
  assign row_out   = row_q;
  assign col_out   = col_q;
  assign rejected  = rej_q;
`ifdef TETRIS_SCORE_EN
  logic [15:0] lines_q, lines_d;
  always_comb
    lines_d = (state_q == S_OVER && start) ? 16'd0
            : (state_q == S_CLEAR && row_full && lines_q != 16'hFFFF) ? lines_q + 16'd1 : lines_q;
  always_ff @(posedge clka or negedge restart_n)
    if (!restart_n) lines_q <= '0;
    else lines_q <= lines_d;
  assign lines_cleared = lines_q;
`else
  assign lines_cleared = '0;
`endif
endmodule

// File: tb/tb_tetris_board_engine.sv
// tb_tetris_board_engine: directed checks of a 4x8 and a 6x10 board engine against hand-derived values
module tb_tetris_board_engine;
`ifdef TETRIS_SCORE_EN
  localparam longint LINES1 = 1;
`else
  localparam longint LINES1 = 0;
`endif
  logic clka, restart_n, start, move_valid, drop_tick;
  logic [1:0] move;
  logic [31:0] b4;
  logic [59:0] b6;
  logic [2:0] s4, s6, row4, col6;
  logic [1:0] p4, p6, r4, r6, col4;
  logic [3:0] row6;
  logic mr4, mr6, rj4, rj6;
  logic [15:0] lc4, lc6;
  logic sel;
  int bw, bh, checks, errors;
  logic [63:0] brd;
  logic [7:0] state_o, piece_o, rot_o, row_o, col_o;
  logic ready_o, rej_o;
  logic [15:0] lines_o;
  logic [7:0] lf;

  tetris_board_engine dut4 (
    .clka(clka), .restart_n(restart_n), .start(start), .move_valid(move_valid), .move(move),
    .move_ready(mr4), .drop_tick(drop_tick), .board_out(b4), .state_out(s4), .piece_out(p4),
    .rot_out(r4), .row_out(row4), .col_out(col4), .rejected(rj4), .lines_cleared(lc4)
  );
  tetris_board_engine #(.BOARD_W(6), .BOARD_H(10)) dut6 (
    .clka(clka), .restart_n(restart_n), .start(start), .move_valid(move_valid), .move(move),
    .move_ready(mr6), .drop_tick(drop_tick), .board_out(b6), .state_out(s6), .piece_out(p6),
    .rot_out(r6), .row_out(row6), .col_out(col6), .rejected(rj6), .lines_cleared(lc6)
  );

  always_comb begin
    brd     = sel ? 64'(b6) : 64'(b4);
    state_o = sel ? 8'(s6) : 8'(s4);
    piece_o = sel ? 8'(p6) : 8'(p4);
    rot_o   = sel ? 8'(r6) : 8'(r4);
    row_o   = sel ? 8'(row6) : 8'(row4);
    col_o   = sel ? 8'(col6) : 8'(col4);
    ready_o = sel ? mr6 : mr4;
    rej_o   = sel ? rj6 : rj4;
    lines_o = sel ? lc6 : lc4;
  end

  function automatic logic [7:0] nx(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction
  function automatic logic [1:0] type_after(input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) l = nx(l);
    return l[1:0];
  endfunction
  always @(posedge clka or negedge restart_n)
    if (!restart_n) lf <= 8'hA5;
    else lf <= nx(lf);

  initial begin
    clka = 0;
    forever #5 clka = ~clka;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required done");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(negedge clka);
  endtask
  task automatic do_move(input logic [1:0] m);
    move_valid = 1; move = m;
    step();
    move_valid = 0; move = 0;
  endtask
  task automatic drop(input int n);
    drop_tick = 1;
    step(n);
    drop_tick = 0;
  endtask
  // idle until the piece generated n edges from now has type t
  task automatic align(input logic [1:0] t, input int n);
    int k = 0;
    while (type_after(lf, n) != t && k < 600) begin
      step();
      k++;
    end
    check("align", longint'(k < 600), 1);
  endtask
  task automatic land_and_clear(input string tag, input int clears, input logic [1:0] nxt);
    int k = 0;
    drop(1);
    check({tag, "_land"}, state_o, 3);
    step();
    while (state_o == 4 && k < 100) begin
      step();
      k++;
    end
    check({tag, "_clear_len"}, k, bh + clears);
    check({tag, "_gen"}, state_o, 1);
    step();
    check({tag, "_next_piece"}, piece_o, nxt);
  endtask

  task automatic run_game();
    int sc, k;
    sc = bw / 2 - 1;
    restart_n = 0; #1;
    check("rst_state", state_o, 0);
    check("rst_board", brd, 0);
    check("rst_ready", ready_o, 0);
    check("rst_lines", lines_o, 0);
    check("rst_rej", rej_o, 0);
    check("rst_pos", {piece_o, rot_o, row_o, col_o}, 0);
    step(2); restart_n = 1; step();
    check("idle_hold", state_o, 0);
    align(2'd0, 1);
    start = 1; step(); start = 0;
    check("gen", state_o, 1);
    step();
    check("spawn_state", state_o, 2);
    check("spawn_piece", piece_o, 0);
    check("spawn_col", col_o, sc);
    check("spawn_ready", ready_o, 1);
    check("spawn_board", brd, 64'b11 << sc);
    start = 1; step(); start = 0;
    check("start_ignored", state_o, 2);
    for (int i = 0; i < sc; i++) do_move(2'd1);
    check("left_col", col_o, 0);
    check("left_norej", rej_o, 0);
    do_move(2'd1);
    check("edge_rej", rej_o, 1);
    check("edge_col", col_o, 0);
    step();
    check("rej_pulse", rej_o, 0);
    do_move(2'd3); do_move(2'd3);
    check("rot", rot_o, 2);
    check("rot_board", brd, 64'b11 << bw);
    do_move(2'd0);
    check("nop_rej", rej_o, 0);
    check("nop_pos", {rot_o, col_o}, 16'h0200);
    drop(bh - 2);
    check("drop_row", row_o, bh - 2);
    if (bw == 4) begin
      align(2'd2, bh + 2);
      land_and_clear("bar1", 0, 2'd2);
    end else begin
      align(2'd0, bh + 2);
      land_and_clear("bar1", 0, 2'd0);
      do_move(2'd3); do_move(2'd3);
      drop(bh - 2);
      check("bar2_row", row_o, bh - 2);
      align(2'd2, bh + 2);
      land_and_clear("bar2", 0, 2'd2);
    end
    move_valid = 1; move = 2'd2; drop_tick = 1; #1;
    check("conflict_ready", ready_o, 0);
    step(); drop_tick = 0; #1;
    check("conflict_row", row_o, 1);
    check("conflict_col", col_o, sc);
    check("pending_ready", ready_o, 1);
    step(); move_valid = 0; move = 0;
    check("pending_col", col_o, sc + 1);
    for (int i = sc + 1; i < bw - 2; i++) do_move(2'd2);
    check("sq_col", col_o, bw - 2);
    drop(bh - 3);
    check("sq_row", row_o, bh - 2);
    drop(1);
    check("sq_land", state_o, 3);
    step();
    k = 0;
    while (state_o == 4 && k < 100) begin
      step();
      k++;
    end
    check("sq_clear_len", k, bh + 1);
    check("sq_board", brd, 64'b11 << ((bh - 1) * bw + bw - 2));
    check("sq_lines", lines_o, LINES1);
    drop_tick = 1;
    k = 0;
    while (state_o != 4 && k < 100) begin
      step();
      k++;
    end
    drop_tick = 0;
    check("reach_clear", state_o, 4);
    restart_n = 0; #1;
    check("midclear_state", state_o, 0);
    check("midclear_board", brd, 0);
    check("midclear_lines", lines_o, 0);
    step(); restart_n = 1; step();
    start = 1; step(); start = 0;
    drop_tick = 1;
    k = 0;
    while (state_o != 5 && k < 3000) begin
      step();
      k++;
    end
    drop_tick = 0;
    check("over_state", state_o, 5);
    check("over_board", brd, (64'b1 << (bw * bh)) - 1);
    step(3);
    check("over_hold", state_o, 5);
    start = 1; step(); start = 0;
    check("over_restart", state_o, 1);
    check("over_cleared", brd, 0);
    check("over_lines", lines_o, 0);
    step();
    check("over_respawn", state_o, 2);
  endtask

  initial begin
    checks = 0; errors = 0;
    restart_n = 0; start = 0; move_valid = 0; move = 0; drop_tick = 0;
    sel = 0; bw = 4; bh = 8;
    step();
    run_game();
    sel = 1; bw = 6; bh = 10;
    run_game();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
